sha3_pad_packer: RTL and testbench

SHA3_PAD_PACKER -- requirements
Module: sha3_pad_packer

---
 rtl/sha3_pkg.sv | 36 +++
 rtl/sha3_pad_mask.sv | 23 ++
 rtl/sha3_pad_packer.sv | 163 ++++++++++++++++
 tb/tb_sha3_pad_packer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 pad/packer: variant enum, rate lookup, pad bytes.
package sha3_pkg;

    localparam int unsigned MAX_RATE_BITS  = 1152;
    localparam int unsigned MAX_RATE_BYTES = MAX_RATE_BITS / 8;
    localparam int unsigned WCNT_W         = 7;
    localparam int unsigned POS_W          = 8;

    localparam logic [7:0] PAD_SHA3   = 8'h06;
    localparam logic [7:0] PAD_KECCAK = 8'h01;
    localparam logic [7:0] PAD_END    = 8'h80;

    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } sha3_mode_t;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HOLD   = 2'd1,
        PADBLK = 2'd2
    } pack_state_t;

    // Rate in 16-bit words for each variant.
    function automatic logic [WCNT_W-1:0] rate_words(input sha3_mode_t m);
        case (m)
            SHA3_224: return WCNT_W'(72);
            SHA3_256: return WCNT_W'(68);
            SHA3_384: return WCNT_W'(52);
            default:  return WCNT_W'(36);
        endcase
    endfunction

endpackage

// File: rtl/sha3_pad_mask.sv
// Combinational OR-mask: pad byte at position p, end marker 0x80 at byte 2R-1.
module sha3_pad_mask
    import sha3_pkg::*;
(
    input  logic [POS_W-1:0]         i_pos,
    input  logic [WCNT_W-1:0]        i_rate_words,
    input  logic [7:0]               i_pad,
    output logic [MAX_RATE_BITS-1:0] o_mask
);

    logic [POS_W-1:0] w_end;

    assign w_end = {i_rate_words, 1'b0} - POS_W'(1);

    always_comb begin
        o_mask = '0;
        for (int k = 0; k < int'(MAX_RATE_BYTES); k++) begin
            o_mask[8*k +: 8] = ((POS_W'(k) == i_pos) ? i_pad   : 8'h00)
                             | ((POS_W'(k) == w_end) ? PAD_END : 8'h00);
        end
    end

endmodule

// File: rtl/sha3_pad_packer.sv
// Packs 16-bit AXI-Stream message words into padded SHA-3 rate blocks.
// Optional SHA3_PAD_KECCAK_EN adds legacy_i to select the original Keccak pad byte.
module sha3_pad_packer
    import sha3_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [WIDTH-1:0]         TDATA_i,
    input  logic [1:0]               TKEEP_i,
    input  logic                     TVALID_i,
    input  logic                     TLAST_i,
    output logic                     TREADY_o,
    input  logic [1:0]               USER_i,
`ifdef SHA3_PAD_KECCAK_EN
    input  logic                     legacy_i,
`endif
    output logic [MAX_RATE_BITS-1:0] blk_data_o,
    output logic                     blk_valid_o,
    input  logic                     blk_ready_i,
    output logic                     blk_last_o,
    output logic                     blk_first_o,
    output logic [1:0]               blk_mode_o
);

    pack_state_t              r_state, w_state_nxt;
    logic [MAX_RATE_BITS-1:0] r_buf, w_buf_nxt;
    logic [WCNT_W-1:0]        r_wcnt, w_wcnt_nxt;
    logic                     r_tready, r_valid;
    logic                     r_last, w_last_nxt;
    logic                     r_first, w_first_nxt;
    logic                     r_in_msg, w_in_msg_nxt;
    logic                     r_padnext, w_padnext_nxt;
    sha3_mode_t               r_mode, w_mode_nxt;

    logic                     w_accept, w_blk_take;
    sha3_mode_t               w_mode;
    logic [WCNT_W-1:0]        w_rate;
    logic [1:0]               w_keep;
    logic [POS_W-1:0]         w_pos, w_mask_pos;
    logic [WIDTH-1:0]         w_word;
    logic [7:0]               w_pad;
    logic [MAX_RATE_BITS-1:0] w_mask;

    assign w_accept   = TVALID_i && r_tready;
    assign w_blk_take = r_valid && blk_ready_i;
    // The first beat of a message uses USER_i directly; later beats use the latched copy.
    assign w_mode     = r_in_msg ? r_mode : sha3_mode_t'(USER_i);
    assign w_rate     = rate_words(w_mode);
    assign w_keep     = TLAST_i ? TKEEP_i : 2'b11;
    assign w_pos      = {r_wcnt, 1'b0} + POS_W'(w_keep[0]) + POS_W'(w_keep[1]);
    assign w_mask_pos = (r_state == PADBLK) ? '0 : w_pos;
    assign w_word     = TDATA_i & WIDTH'({{8{w_keep[1]}}, {8{w_keep[0]}}});

`ifdef SHA3_PAD_KECCAK_EN
    logic r_legacy;
    logic w_legacy;

    assign w_legacy = r_in_msg ? r_legacy : legacy_i;
    assign w_pad    = w_legacy ? PAD_KECCAK : PAD_SHA3;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)                   r_legacy <= 1'b0;
        else if (w_accept && !r_in_msg) r_legacy <= legacy_i;
    end
`else
    assign w_pad = PAD_SHA3;
`endif

    sha3_pad_mask u_mask (
        .i_pos        (w_mask_pos),
        .i_rate_words (w_rate),
        .i_pad        (w_pad),
        .o_mask       (w_mask)
    );

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt   = r_state;
        w_buf_nxt     = r_buf;
        w_wcnt_nxt    = r_wcnt;
        w_last_nxt    = r_last;
        w_first_nxt   = r_first;
        w_in_msg_nxt  = r_in_msg;
        w_padnext_nxt = r_padnext;
        w_mode_nxt    = r_mode;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_in_msg_nxt = 1'b1;
                    w_mode_nxt   = w_mode;
                    w_buf_nxt[{r_wcnt, 4'b0000} +: WIDTH] = w_word;
                    if (TLAST_i) begin
                        w_state_nxt = HOLD;
                        if (w_pos < {w_rate, 1'b0}) begin
                            w_buf_nxt  = w_buf_nxt | w_mask;
                            w_last_nxt = 1'b1;
                        end else begin
                            w_last_nxt    = 1'b0;
                            w_padnext_nxt = 1'b1;
                        end
                    end else if (r_wcnt == w_rate - WCNT_W'(1)) begin
                        w_state_nxt = HOLD;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_wcnt_nxt = r_wcnt + WCNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (w_blk_take) begin
                    w_buf_nxt     = '0;
                    w_wcnt_nxt    = '0;
                    w_first_nxt   = r_last;
                    w_padnext_nxt = 1'b0;
                    w_in_msg_nxt  = r_in_msg && !r_last;
                    w_state_nxt   = r_padnext ? PADBLK : FILL;
                end
            end
            PADBLK: begin
                w_buf_nxt   = w_mask;
                w_last_nxt  = 1'b1;
                w_state_nxt = HOLD;
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= FILL;
            r_buf     <= '0;
            r_wcnt    <= '0;
            r_tready  <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_first   <= 1'b1;
            r_in_msg  <= 1'b0;
            r_padnext <= 1'b0;
            r_mode    <= SHA3_224;
        end else begin
            r_state   <= w_state_nxt;
            r_buf     <= w_buf_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_tready  <= (w_state_nxt == FILL);
            r_valid   <= (w_state_nxt == HOLD);
            r_last    <= w_last_nxt;
            r_first   <= w_first_nxt;
            r_in_msg  <= w_in_msg_nxt;
            r_padnext <= w_padnext_nxt;
            r_mode    <= w_mode_nxt;
        end
    end

    assign TREADY_o    = r_tready;
    assign blk_valid_o = r_valid;
    assign blk_data_o  = r_buf;
    assign blk_last_o  = r_last;
    assign blk_first_o = r_first;
    assign blk_mode_o  = r_mode;

endmodule

// File: tb/tb_sha3_pad_packer.sv
// Scoreboard bench for sha3_pad_packer: directed messages, expected blocks queued by hand.
module tb_sha3_pad_packer;

    localparam int unsigned BW = 1152;

    logic          ACLK;
    logic          ARESET;
    logic [15:0]   TDATA_i;
    logic [1:0]    TKEEP_i;
    logic          TVALID_i;
    logic          TLAST_i;
    logic          TREADY_o;
    logic [1:0]    USER_i;
    logic [BW-1:0] blk_data_o;
    logic          blk_valid_o;
    logic          blk_ready_i;
    logic          blk_last_o;
    logic          blk_first_o;
    logic [1:0]    blk_mode_o;
`ifdef SHA3_PAD_KECCAK_EN
    logic          legacy_i;
    initial legacy_i = 1'b0;
`endif

    typedef struct packed {
        logic [BW-1:0] d;
        logic          last;
        logic          first;
        logic [1:0]    mode;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    sha3_pad_packer #(.WIDTH(16)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .TDATA_i     (TDATA_i),
        .TKEEP_i     (TKEEP_i),
        .TVALID_i    (TVALID_i),
        .TLAST_i     (TLAST_i),
        .TREADY_o    (TREADY_o),
        .USER_i      (USER_i),
`ifdef SHA3_PAD_KECCAK_EN
        .legacy_i    (legacy_i),
`endif
        .blk_data_o  (blk_data_o),
        .blk_valid_o (blk_valid_o),
        .blk_ready_i (blk_ready_i),
        .blk_last_o  (blk_last_o),
        .blk_first_o (blk_first_o),
        .blk_mode_o  (blk_mode_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic logic [7:0] gen(input int kind, input int i);
        case (kind)
            0:       return 8'(i);
            1:       return 8'hAA;
            default: return 8'h61;
        endcase
    endfunction

    function automatic logic [BW-1:0] data_bytes(input int n, input int kind);
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = gen(kind, i);
        return v;
    endfunction

    task automatic push_exp(input logic [BW-1:0] d, input logic last, input logic first,
                            input logic [1:0] mode);
        exp_t e;
        e.d = d; e.last = last; e.first = first; e.mode = mode;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted block is compared against the head of the scoreboard.
    always @(negedge ACLK) begin
        if (!ARESET && blk_valid_o && blk_ready_i) begin
            exp_t e;
            int   bad;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_block: got a block, required none (last=%0b first=%0b)",
                         blk_last_o, blk_first_o);
            end else begin
                e   = exp_q.pop_front();
                bad = -1;
                for (int i = BW/8 - 1; i >= 0; i--)
                    if (blk_data_o[8*i +: 8] !== e.d[8*i +: 8]) bad = i;
                if (bad >= 0 || blk_last_o !== e.last || blk_first_o !== e.first
                    || blk_mode_o !== e.mode) begin
                    n_fail++;
                    if (bad >= 0)
                        $display("FAIL block_data: byte %0d got %02h required %02h",
                                 bad, blk_data_o[8*bad +: 8], e.d[8*bad +: 8]);
                    else
                        $display("FAIL block_flags: got last=%0b first=%0b mode=%0d required last=%0b first=%0b mode=%0d",
                                 blk_last_o, blk_first_o, blk_mode_o, e.last, e.first, e.mode);
                end
            end
        end
    end

    task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l,
                             input logic [1:0] u);
        int   cyc;
        logic hs;
        TDATA_i = d; TKEEP_i = k; TLAST_i = l; USER_i = u; TVALID_i = 1'b1;
        hs = 1'b0; cyc = 0;
        while (!hs && cyc < 300) begin
            @(negedge ACLK);
            hs = TREADY_o;
            @(posedge ACLK); #1;
            cyc++;
        end
        TVALID_i = 1'b0;
        if (!hs) begin
            n_tests++; n_fail++;
            $display("FAIL beat_timeout: got TREADY_o=0 for %0d cycles, required 1", cyc);
        end
    endtask

    // Later beats drive the inverted mode to confirm USER_i is latched on the first beat.
    task automatic send_msg(input logic [1:0] mode, input int n, input int kind);
        int         nw;
        logic [7:0] lo, hi;
        logic       l;
        if (n == 0) begin
            send_beat(16'hBEEF, 2'b00, 1'b1, mode);
        end else begin
            nw = (n + 1) / 2;
            for (int w = 0; w < nw; w++) begin
                lo = gen(kind, 2*w);
                hi = (2*w + 1 < n) ? gen(kind, 2*w + 1) : 8'hEE;
                l  = (w == nw - 1);
                send_beat({hi, lo}, (l && (n % 2 == 1)) ? 2'b01 : 2'b11, l,
                          (w == 0) ? mode : ~mode);
            end
        end
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(posedge ACLK); #1;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d blocks pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        logic [BW-1:0] e;
        logic [BW-1:0] d0;
        int            cyc;

        ARESET = 1'b1; TVALID_i = 1'b0; TLAST_i = 1'b0; TKEEP_i = 2'b11;
        TDATA_i = '0; USER_i = 2'd0; blk_ready_i = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_tready", 32'(TREADY_o), 32'd0);
        check("rst_valid",  32'(blk_valid_o), 32'd0);
        check("rst_last",   32'(blk_last_o), 32'd0);
        check("rst_first",  32'(blk_first_o), 32'd1);
        check("rst_mode",   32'(blk_mode_o), 32'd0);
        check("rst_data_zero", 32'(blk_data_o != '0), 32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check("tready_after_reset", 32'(TREADY_o), 32'd1);
        @(posedge ACLK); #1;

        // Empty message, SHA3-256.
        e = '0; e[7:0] = 8'h06; e[135*8 +: 8] = 8'h80;
        push_exp(e, 1'b1, 1'b1, 2'd1);
        send_msg(2'd1, 0, 0);

        // 135 bytes, SHA3-256: pad lands on the final rate byte as 0x86.
        e = data_bytes(135, 0); e[135*8 +: 8] = 8'h86;
        push_exp(e, 1'b1, 1'b1, 2'd1);
        send_msg(2'd1, 135, 0);

        // 136 bytes, SHA3-256: full data block then pad-only block.
        push_exp(data_bytes(136, 0), 1'b0, 1'b1, 2'd1);
        e = '0; e[7:0] = 8'h06; e[135*8 +: 8] = 8'h80;
        push_exp(e, 1'b1, 1'b0, 2'd1);
        send_msg(2'd1, 136, 0);

        // 73 words of 0xAAAA, SHA3-224.
        push_exp(data_bytes(144, 1), 1'b0, 1'b1, 2'd0);
        e = '0; e[15:0] = 16'hAAAA; e[23:16] = 8'h06; e[143*8 +: 8] = 8'h80;
        push_exp(e, 1'b1, 1'b0, 2'd0);
        send_msg(2'd0, 146, 1);

        // 72 bytes, SHA3-512: exact-rate message.
        push_exp(data_bytes(72, 0), 1'b0, 1'b1, 2'd3);
        e = '0; e[7:0] = 8'h06; e[71*8 +: 8] = 8'h80;
        push_exp(e, 1'b1, 1'b0, 2'd3);
        send_msg(2'd3, 72, 0);
        wait_drain();

        // Back-pressure: 5 bytes, SHA3-384, blk_ready_i low for 5 cycles in HOLD.
        blk_ready_i = 1'b0;
        e = data_bytes(5, 0); e[5*8 +: 8] = 8'h06; e[103*8 +: 8] = 8'h80;
        push_exp(e, 1'b1, 1'b1, 2'd2);
        send_msg(2'd2, 5, 0);
        cyc = 0;
        @(negedge ACLK);
        while (!blk_valid_o && cyc < 20) begin @(negedge ACLK); cyc++; end
        check("stall_valid_seen", 32'(blk_valid_o), 32'd1);
        d0 = blk_data_o;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge ACLK);
            check("stall_tready", 32'(TREADY_o), 32'd0);
            check("stall_data_stable", 32'(blk_data_o != d0), 32'd0);
        end
        @(posedge ACLK); #1;
        blk_ready_i = 1'b1;
        wait_drain();

        // Reset after 10 words discards the partial message.
        for (int w = 0; w < 10; w++) send_beat(16'h1234, 2'b11, 1'b0, 2'd2);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("midrst_tready", 32'(TREADY_o), 32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("midrst_no_block", 32'(blk_valid_o), 32'd0);

        // 1-byte message 0x61, SHA3-512.
        e = '0; e[7:0] = 8'h61; e[15:8] = 8'h06; e[71*8 +: 8] = 8'h80;
        push_exp(e, 1'b1, 1'b1, 2'd3);
        send_msg(2'd3, 1, 2);
        wait_drain();

        repeat (4) @(posedge ACLK);
        @(negedge ACLK);
        check("idle_valid", 32'(blk_valid_o), 32'd0);
        check("idle_tready", 32'(TREADY_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
